// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched_if
// Purpose  : Configuration handshake bundle for clk_div_sched. The register
//            bank (master) offers a half-period and the divider controller
//            (slave) accepts it and reports completion or rejection.
// Signals  : cfg_valid  master->slave  new half-period offered
//            cfg_half   master->slave  offered half-period (clk_in cycles)
//            cfg_ready  slave->master  controller can accept cfg_half
//            cfg_done   slave->master  one-cycle pulse, new ratio in effect
//            cfg_err    slave->master  one-cycle pulse, offered value rejected
// Note     : CNT_W must match the CNT_W of the attached clk_div_sched.
// Revision : 1.0  initial release
// ============================================================================
interface clk_div_sched_if #(
  parameter int CNT_W = 16
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_done,
    output cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Purpose  : Run-time programmable 50% duty clock divider. Ratio changes and
//            start/stop requests are applied only at phase boundaries so the
//            divided clock never shows a glitch or runt phase and always parks
//            low.
// Ports    : clk_in     system clock
//            reset_n    asynchronous active-low reset
//            enable     run request (level)
//            cfg        clk_div_sched_if.slave config handshake
//            clk_out    divided clock, period 2*cur_half
//            rise_tick  pulse in the first cycle clk_out is high
//            fall_tick  pulse in the first cycle clk_out is low
//            running    high while the divider runs (RUN or PEND)
//            cur_half   half-period currently in effect
// Option   : CLK_DIV_SCHED_CFG_CHECK_EN - when defined, offered values below
//            MIN_HALF are handshaked but discarded and cfg_err pulses; when
//            undefined cfg_err is tied low and only 0 is clamped to 1.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_sched #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 10,
  parameter int MIN_HALF     = 1
) (
  input  wire logic        clk_in,
  input  wire logic        reset_n,
  input  wire logic        enable,
  clk_div_sched_if.slave   cfg,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_DEFAULT_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] C_MIN_HALF     = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_counter, w_counter_nxt;
  logic [CNT_W-1:0] r_cur_half, w_cur_half_nxt;
  logic [CNT_W-1:0] r_shadow, w_shadow_nxt;
  logic             r_clk_out, w_clk_out_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             r_running, w_running_nxt;
  logic             r_cfg_ready, w_cfg_ready_nxt;
  logic             r_cfg_done, w_cfg_done_nxt;
  // Set when a value was accepted while stopped; it is applied next cycle.
  logic             r_stop_apply, w_stop_apply_nxt;

  logic             w_accept;
  logic             w_below_min;
  logic             w_reject;
  logic             w_take;
  logic             w_boundary;
  logic [CNT_W-1:0] w_half_in;

  assign w_accept    = cfg.cfg_valid && r_cfg_ready;
  assign w_below_min = cfg.cfg_half < C_MIN_HALF;
  assign w_half_in   = (cfg.cfg_half == '0) ? C_ONE : cfg.cfg_half;
  assign w_take      = w_accept && !w_reject;
  assign w_boundary  = (r_counter == (r_cur_half - C_ONE));

`ifdef CLK_DIV_SCHED_CFG_CHECK_EN
  logic r_cfg_err;

  assign w_reject = w_accept && w_below_min;

  // Pulse lands in the cycle after the rejected transfer.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
    end
  end

  assign cfg.cfg_err = r_cfg_err;
`else
  logic w_unused_below_min;

  assign w_reject           = 1'b0;
  assign w_unused_below_min = w_below_min;
  assign cfg.cfg_err        = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_counter_nxt    = r_counter;
    w_clk_out_nxt    = r_clk_out;
    w_cur_half_nxt   = r_cur_half;
    w_shadow_nxt     = r_shadow;
    w_stop_apply_nxt = 1'b0;
    w_cfg_done_nxt   = 1'b0;
    w_rise_nxt       = 1'b0;
    w_fall_nxt       = 1'b0;

    if (w_take) begin
      w_shadow_nxt = w_half_in;
    end

    case (r_state)
      ST_STOP: begin
        w_counter_nxt = '0;
        w_clk_out_nxt = 1'b0;
        if (r_stop_apply) begin
          w_cur_half_nxt = r_shadow;
          w_cfg_done_nxt = 1'b1;
        end
        // A transfer taken while stopped holds STOP for one more cycle so the
        // new ratio is in place before the first low phase starts.
        if (w_take) begin
          w_stop_apply_nxt = 1'b1;
        end else if (enable) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN, ST_PEND: begin
        if (w_boundary) begin
          w_counter_nxt = '0;
          if (r_clk_out) begin
            w_clk_out_nxt = 1'b0;
            w_fall_nxt    = 1'b1;
          end else begin
            // Low-end boundary: the only point where a ratio change or a
            // stop can take effect without shortening a phase.
            if (r_state == ST_PEND) begin
              w_cur_half_nxt = r_shadow;
              w_cfg_done_nxt = 1'b1;
            end
            if (enable) begin
              w_clk_out_nxt = 1'b1;
              w_rise_nxt    = 1'b1;
              w_state_nxt   = ST_RUN;
            end else begin
              w_state_nxt   = ST_STOP;
            end
          end
        end else begin
          w_counter_nxt = r_counter + C_ONE;
        end

        // Transfers only happen in RUN (cfg_ready is low in PEND). A value
        // taken on a low-end boundary waits for the following one; if that
        // boundary is also the stop point, it is applied from STOP instead.
        if (w_take) begin
          if (w_boundary && !r_clk_out && !enable) begin
            w_stop_apply_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_PEND;
          end
        end
      end

      default: begin
        w_state_nxt   = ST_STOP;
        w_counter_nxt = '0;
        w_clk_out_nxt = 1'b0;
      end
    endcase

    w_cfg_ready_nxt = (w_state_nxt != ST_PEND) && !w_stop_apply_nxt;
    w_running_nxt   = (w_state_nxt != ST_STOP);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_STOP;
      r_counter    <= '0;
      r_clk_out    <= 1'b0;
      r_cur_half   <= C_DEFAULT_HALF;
      r_shadow     <= C_DEFAULT_HALF;
      r_cfg_ready  <= 1'b1;
      r_cfg_done   <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_running    <= 1'b0;
      r_stop_apply <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_counter    <= w_counter_nxt;
      r_clk_out    <= w_clk_out_nxt;
      r_cur_half   <= w_cur_half_nxt;
      r_shadow     <= w_shadow_nxt;
      r_cfg_ready  <= w_cfg_ready_nxt;
      r_cfg_done   <= w_cfg_done_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_running    <= w_running_nxt;
      r_stop_apply <= w_stop_apply_nxt;
    end
  end

  assign clk_out       = r_clk_out;
  assign rise_tick     = r_rise;
  assign fall_tick     = r_fall;
  assign running       = r_running;
  assign cur_half      = r_cur_half;
  assign cfg.cfg_ready = r_cfg_ready;
  assign cfg.cfg_done  = r_cfg_done;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Purpose  : Directed self-checking bench for clk_div_sched. Each scenario
//            task drives stimulus and compares against hand-computed values.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_sched;

  localparam int CNT_W        = 16;
  localparam int DEFAULT_HALF = 10;
`ifdef CLK_DIV_SCHED_CFG_CHECK_EN
  localparam int MIN_HALF     = 2;
`else
  localparam int MIN_HALF     = 1;
`endif

  logic             clk_in = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic             running;
  logic [CNT_W-1:0] cur_half;

  int checks   = 0;
  int failures = 0;

  clk_div_sched_if #(.CNT_W(CNT_W)) cfg ();

  clk_div_sched #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF),
    .MIN_HALF     (MIN_HALF)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .cfg       (cfg),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .running   (running),
    .cur_half  (cur_half)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    cfg.cfg_valid = 1'b0;
    cfg.cfg_half  = '0;
    reset_n       = 1'b0;
    enable        = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
    checks++; if (cur_half !== 16'd10) begin failures++; $display("FAIL reset_cur_half got=%0d exp=10", cur_half); end
    checks++; if (cfg.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg.cfg_ready); end
    checks++; if (cfg.cfg_done !== 1'b0) begin failures++; $display("FAIL reset_cfg_done got=%b exp=0", cfg.cfg_done); end
    checks++; if (cfg.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg.cfg_err); end
    checks++; if (rise_tick !== 1'b0 || fall_tick !== 1'b0) begin failures++; $display("FAIL reset_ticks got=%b%b exp=00", rise_tick, fall_tick); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
  endtask

  // Start from STOP at half=10: rise after 11 edges, then 10/10 phases.
  task automatic test_start();
    int n;
    int hc;
    int lc;
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rise_tick && n < 40);
    checks++; if (n != 11) begin failures++; $display("FAIL start_first_rise got=%0d exp=11", n); end
    checks++; if (running !== 1'b1 || clk_out !== 1'b1) begin failures++; $display("FAIL start_run got=%b%b exp=11", running, clk_out); end
    hc = 1;
    do begin step(); if (clk_out) hc++; end while (clk_out && hc < 40);
    checks++; if (hc != 10 || fall_tick !== 1'b1) begin failures++; $display("FAIL start_high_len got=%0d/%b exp=10/1", hc, fall_tick); end
    lc = 1;
    do begin step(); if (!clk_out) lc++; end while (!clk_out && lc < 40);
    checks++; if (lc != 10 || rise_tick !== 1'b1) begin failures++; $display("FAIL start_low_len got=%0d/%b exp=10/1", lc, rise_tick); end
  endtask

  // Offer half=3 in the 4th high cycle; applied at the next low-end boundary.
  task automatic test_cfg_run();
    int n;
    int hc;
    int lc;
    int early;
    repeat (3) step();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd3;
    step();
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_ready !== 1'b0) begin failures++; $display("FAIL cfgrun_ready_low got=%b exp=0", cfg.cfg_ready); end
    checks++; if (clk_out !== 1'b1 || cur_half !== 16'd10) begin failures++; $display("FAIL cfgrun_unchanged got=%b/%0d exp=1/10", clk_out, cur_half); end
    n = 0;
    early = 0;
    do begin
      step(); n++;
      if (cfg.cfg_done && !rise_tick) early++;
    end while (!rise_tick && n < 60);
    checks++; if (n != 16) begin failures++; $display("FAIL cfgrun_latency got=%0d exp=16", n); end
    checks++; if (early != 0) begin failures++; $display("FAIL cfgrun_early_done got=%0d exp=0", early); end
    checks++; if (cfg.cfg_done !== 1'b1 || cur_half !== 16'd3 || cfg.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL cfgrun_apply got=%b/%0d/%b exp=1/3/1", cfg.cfg_done, cur_half, cfg.cfg_ready);
    end
    hc = 1;
    do begin step(); if (clk_out) hc++; end while (clk_out && hc < 40);
    checks++; if (hc != 3 || fall_tick !== 1'b1) begin failures++; $display("FAIL cfgrun_high_len got=%0d exp=3", hc); end
    lc = 1;
    do begin step(); if (!clk_out) lc++; end while (!clk_out && lc < 40);
    checks++; if (lc != 3 || rise_tick !== 1'b1 || cfg.cfg_done !== 1'b0) begin
      failures++; $display("FAIL cfgrun_low_len got=%0d/%b exp=3/0", lc, cfg.cfg_done);
    end
  endtask

  // Switch to half=4, drop enable in high cycle 2: 4 high, 4 low, then STOP.
  task automatic test_stop();
    int n;
    int hc;
    int lc;
    int bad;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd4;
    step();
    cfg.cfg_valid = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rise_tick && n < 30);
    checks++; if (cfg.cfg_done !== 1'b1 || cur_half !== 16'd4) begin failures++; $display("FAIL stop_setup got=%b/%0d exp=1/4", cfg.cfg_done, cur_half); end
    step();
    enable = 1'b0;
    hc = 2;
    do begin step(); if (clk_out) hc++; end while (clk_out && hc < 40);
    checks++; if (hc != 4 || fall_tick !== 1'b1) begin failures++; $display("FAIL stop_high_len got=%0d exp=4", hc); end
    lc = 0;
    do begin step(); lc++; end while (running && lc < 40);
    checks++; if (lc != 4 || clk_out !== 1'b0) begin failures++; $display("FAIL stop_low_len got=%0d/%b exp=4/0", lc, clk_out); end
    bad = 0;
    repeat (30) begin
      step();
      if (rise_tick || clk_out || running) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stop_parked got=%0d exp=0", bad); end
  endtask

  // half=1 accepted in STOP, then enable: toggle every cycle.
  task automatic test_half_one();
    int bad;
    logic exp_clk;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd1;
    step();
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_ready !== 1'b0 || cfg.cfg_done !== 1'b0 || cur_half !== 16'd4) begin
      failures++; $display("FAIL half1_accept got=%b/%b/%0d exp=0/0/4", cfg.cfg_ready, cfg.cfg_done, cur_half);
    end
    step();
    checks++; if (cfg.cfg_done !== 1'b1 || cur_half !== 16'd1 || cfg.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL half1_apply got=%b/%0d/%b exp=1/1/1", cfg.cfg_done, cur_half, cfg.cfg_ready);
    end
    enable = 1'b1;
    step();
    checks++; if (clk_out !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL half1_run got=%b/%b exp=0/1", clk_out, running); end
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_clk = (i % 2) == 1;
      if (clk_out !== exp_clk || rise_tick !== exp_clk || fall_tick !== !exp_clk) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL half1_toggle got=%0d exp=0", bad); end
  endtask

  // Reset while PEND (cur_half=5, shadow=7): pending update discarded.
  task automatic test_reset_pend();
    int n;
    int bad;
    enable = 1'b1;
    step();
    step();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd5;
    step();
    cfg.cfg_valid = 1'b0;
    n = 0;
    do begin step(); n++; end while (!cfg.cfg_done && n < 40);
    checks++; if (cur_half !== 16'd5 || clk_out !== 1'b1) begin failures++; $display("FAIL rstpend_setup got=%0d/%b exp=5/1", cur_half, clk_out); end
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd7;
    step();
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_ready !== 1'b0 || clk_out !== 1'b1) begin failures++; $display("FAIL rstpend_pend got=%b/%b exp=0/1", cfg.cfg_ready, clk_out); end
    reset_n = 1'b0;
    #1;
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL rstpend_async_low got=%b exp=0", clk_out); end
    enable = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    checks++; if (cur_half !== 16'd10 || cfg.cfg_ready !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL rstpend_after got=%0d/%b/%b exp=10/1/0", cur_half, cfg.cfg_ready, running);
    end
    bad = 0;
    repeat (20) begin
      step();
      if (cfg.cfg_done || cur_half !== 16'd10) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstpend_no_done got=%0d exp=0", bad); end
  endtask

`ifndef CLK_DIV_SCHED_CFG_CHECK_EN
  // cfg_half=0 offered in STOP is clamped to 1.
  task automatic test_zero_clamp();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd0;
    step();
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_err !== 1'b0 || cfg.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL zero_accept got=%b/%b exp=0/0", cfg.cfg_err, cfg.cfg_ready);
    end
    step();
    checks++; if (cfg.cfg_done !== 1'b1 || cur_half !== 16'd1) begin
      failures++; $display("FAIL zero_clamp got=%b/%0d exp=1/1", cfg.cfg_done, cur_half);
    end
  endtask
`else
  // cfg_half=1 with MIN_HALF=2: handshaked, discarded, cfg_err pulse.
  task automatic test_cfg_check();
    int n;
    int hc;
    int bad;
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rise_tick && n < 40);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_half  = 16'd1;
    step();
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_err !== 1'b1 || cfg.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL check_err_pulse got=%b/%b exp=1/1", cfg.cfg_err, cfg.cfg_ready);
    end
    checks++; if (cur_half !== 16'd10 || clk_out !== 1'b1) begin failures++; $display("FAIL check_unchanged got=%0d/%b exp=10/1", cur_half, clk_out); end
    step();
    checks++; if (cfg.cfg_err !== 1'b0) begin failures++; $display("FAIL check_err_single got=%b exp=0", cfg.cfg_err); end
    hc = 3;
    do begin step(); if (clk_out) hc++; end while (clk_out && hc < 40);
    checks++; if (hc != 10) begin failures++; $display("FAIL check_high_len got=%0d exp=10", hc); end
    bad = 0;
    repeat (25) begin
      step();
      if (cfg.cfg_done || cfg.cfg_err || cur_half !== 16'd10) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL check_no_done got=%0d exp=0", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_cfg_run();
    test_stop();
`ifndef CLK_DIV_SCHED_CFG_CHECK_EN
    test_half_one();
`endif
    test_reset_pend();
`ifndef CLK_DIV_SCHED_CFG_CHECK_EN
    test_zero_clamp();
`else
    test_cfg_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
